lcd_write_arbiter: RTL

- Shares the single SPI writer (lcd_write) between several LCD command/pixel sources: lcd_init, the character renderer, and future sources such as a screen-clear/rectangle-fill engine.
- Replaces the two-way init/show_char mux.
- Grants the writer for a whole burst (window set plus pixel stream), so one source's command sequence is never interleaved with another's.
- Enforces the rule that nothing but init reaches the panel before init_done.

---
 rtl/lcd_pkg.sv | 14 +
 rtl/lcd_write_arbiter_rr_pick.sv | 29 ++
 rtl/lcd_write_arbiter.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared LCD word format, requester indices and arbiter state encoding
package lcd_pkg;
   localparam int LCD_DW     = 9;
   localparam int LCD_DC_BIT = 8;

   localparam int REQ_INIT = 0;
   localparam int REQ_CHAR = 1;
   localparam int REQ_FILL = 2;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } arb_state_e;
endpackage

// File: rtl/lcd_write_arbiter_rr_pick.sv
// rtl/lcd_write_arbiter_rr_pick.sv - combinational round-robin picker over indices 1..N-1
module rr_pick #(
   parameter int N  = 3,
   parameter int PW = $clog2(N)
) (
   input  logic [N-1:0]  eligible_i,
   input  logic [PW-1:0] rr_ptr_i,
   output logic [N-1:0]  winner_o,
   output logic [PW-1:0] winner_idx_o,
   output logic          valid_o
);
   logic [PW-1:0] cand;

   // Index 0 (init) never takes part: the search starts after rr_ptr and wraps N-1 -> 1.
   always_comb begin
      winner_o     = '0;
      winner_idx_o = '0;
      valid_o      = 1'b0;
      cand         = '0;
      for (int o = 0; o < N - 1; o++) begin
         cand = PW'(((int'(rr_ptr_i) + o) % (N - 1)) + 1);
         if (!valid_o && eligible_i[cand]) begin
            valid_o        = 1'b1;
            winner_o[cand] = 1'b1;
            winner_idx_o   = cand;
         end
      end
   end
endmodule

// File: rtl/lcd_write_arbiter.sv
// rtl/lcd_write_arbiter.sv - burst-granting arbiter sharing one lcd_write between sources
module lcd_write_arbiter
   import lcd_pkg::*;
#(
   parameter int NREQ    = 3,
   parameter int DW      = LCD_DW,
   parameter int TIMEOUT = 4096,
   parameter int TW      = 13
) (
   input  logic              sys_clk,
   input  logic              sys_rst_n,
   input  logic              init_done,
   input  logic [NREQ-1:0]   req,
   input  logic [NREQ-1:0]   wr_en_i,
   input  logic [NREQ*DW-1:0] data_i,
   input  logic              wr_done,
   output logic [NREQ-1:0]   gnt,
   output logic [NREQ-1:0]   wr_done_o,
   output logic [DW-1:0]     data,
   output logic              en_write,
   output logic              busy,
   output logic              timeout_p,
   output logic              proto_err
);
   localparam int PW = $clog2(NREQ);

   arb_state_e    state_q, state_d;
   logic [NREQ-1:0] gnt_q, gnt_d;
   logic [NREQ-1:0] mask_q, mask_d;
   logic [DW-1:0] data_q, data_d;
   logic          en_write_q, en_write_d;
   logic          inflight_q, inflight_d;
   logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
   logic [PW-1:0] rr_ptr_q, rr_ptr_d;
   logic          timeout_p_q, timeout_p_d;
   logic          proto_err_q, proto_err_d;

   logic [PW-1:0]   g_idx;
   logic [NREQ-1:0] elig_run;
   logic [NREQ-1:0] rr_win;
   logic [PW-1:0]   rr_win_idx;
   logic            rr_valid;
   logic            req_g, wr_en_g, accept, done, idle_now, force_rel, tmo_hit;
   logic [DW-1:0]   data_g;

   always_comb begin
      g_idx = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (gnt_q[i]) g_idx = PW'(i);
      end
   end

   always_comb begin
      elig_run           = req & ~mask_q;
      elig_run[REQ_INIT] = 1'b0;
   end

   rr_pick #(.N(NREQ), .PW(PW)) u_rr_pick (
      .eligible_i   (elig_run),
      .rr_ptr_i     (rr_ptr_q),
      .winner_o     (rr_win),
      .winner_idx_o (rr_win_idx),
      .valid_o      (rr_valid)
   );

   assign req_g     = |(req & gnt_q);
   assign wr_en_g   = |(wr_en_i & gnt_q);
   assign data_g    = data_i[g_idx*DW +: DW];
   assign accept    = (state_q == ST_GRANT) && wr_en_g && !inflight_q;
   assign done      = inflight_q && wr_done;
   assign idle_now  = !inflight_q || wr_done;
   // A re-init takes the writer back from any run-phase holder.
   assign force_rel = !init_done && !gnt_q[REQ_INIT];
   assign tmo_hit   = (tmo_cnt_q == TW'(TIMEOUT - 1));

   always_comb begin
      state_d     = state_q;
      gnt_d       = gnt_q;
      data_d      = data_q;
      en_write_d  = 1'b0;
      inflight_d  = inflight_q;
      tmo_cnt_d   = tmo_cnt_q;
      mask_d      = mask_q & req;
      rr_ptr_d    = rr_ptr_q;
      timeout_p_d = 1'b0;
      proto_err_d = proto_err_q;
      case (state_q)
         ST_IDLE: begin
            tmo_cnt_d = '0;
            if (!init_done) begin
               if (req[REQ_INIT]) begin
                  state_d         = ST_GRANT;
                  gnt_d           = '0;
                  gnt_d[REQ_INIT] = 1'b1;
                  rr_ptr_d        = PW'(REQ_INIT);
               end
            end else if (rr_valid) begin
               state_d  = ST_GRANT;
               gnt_d    = rr_win;
               rr_ptr_d = rr_win_idx;
            end
         end
         ST_GRANT: begin
            if (done) inflight_d = 1'b0;
            if (wr_en_g) begin
               if (inflight_q) begin
                  proto_err_d = 1'b1;
               end else begin
                  data_d     = data_g;
                  en_write_d = 1'b1;
                  inflight_d = 1'b1;
               end
            end
            if (accept)          tmo_cnt_d = '0;
            else if (!inflight_q) tmo_cnt_d = tmo_cnt_q + TW'(1);
            if (idle_now && !accept && (!req_g || force_rel)) begin
               state_d = ST_IDLE;
               gnt_d   = '0;
            end else if (!inflight_q && !accept && tmo_hit) begin
               state_d     = ST_IDLE;
               gnt_d       = '0;
               timeout_p_d = 1'b1;
               mask_d      = mask_d | gnt_q;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q     <= ST_IDLE;
         gnt_q       <= '0;
         mask_q      <= '0;
         data_q      <= '0;
         en_write_q  <= 1'b0;
         inflight_q  <= 1'b0;
         tmo_cnt_q   <= '0;
         rr_ptr_q    <= PW'(NREQ - 1);
         timeout_p_q <= 1'b0;
         proto_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         gnt_q       <= gnt_d;
         mask_q      <= mask_d;
         data_q      <= data_d;
         en_write_q  <= en_write_d;
         inflight_q  <= inflight_d;
         tmo_cnt_q   <= tmo_cnt_d;
         rr_ptr_q    <= rr_ptr_d;
         timeout_p_q <= timeout_p_d;
         proto_err_q <= proto_err_d;
      end
   end

   assign gnt       = gnt_q;
   assign data      = data_q;
   assign en_write  = en_write_q;
   assign timeout_p = timeout_p_q;
   assign proto_err = proto_err_q;
   assign busy      = (state_q == ST_GRANT) | inflight_q;
   assign wr_done_o = gnt_q & {NREQ{wr_done}};
endmodule
